// File: rtl/adc_readout_seq.sv
// Row-by-row pixel readout sequencer on CLK_HS: takes the exposure hand-off (FSMIND1),
// walks every row through settle/sample/convert/reset, then returns control via FSMIND0.
module adc_readout_seq #(
    parameter int unsigned C_NUM_ROWS    = 160,
    parameter int unsigned C_SETTLE      = 8,
    parameter int unsigned C_ADC_TIMEOUT = 64,
    parameter int unsigned C_RST_CYC     = 4
) (
    input  logic        CLK_HS,
    input  logic        RESET,
    input  logic        FSMIND1,
    output logic        FSMIND1ACK,
    output logic        FSMIND0,
    input  logic        FSMIND0ACK,
    output logic [7:0]  ROW_ADDR,
    output logic        ROW_SEL,
    output logic        ADC_SAMPLE,
    input  logic        ADC_DONE,
    output logic        ROW_RST,
    output logic        ADC_ERR,
    output logic [31:0] FRAME_CNT,
    output logic [7:0]  fsm_stat
);

    // Encodings double as the fsm_stat debug codes.
    typedef enum logic [7:0] {
        StIdle   = 8'h01,
        StSettle = 8'h02,
        StSample = 8'h04,
        StConv   = 8'h08,
        StRowRst = 8'h10,
        StNext   = 8'h20,
        StDone   = 8'h40
    } state_e;

    state_e      state;
    logic [15:0] cnt;
    logic        fsmind1_f1, fsmind1_f2;
    logic        fsmind0ack_f1, fsmind0ack_f2;

    // Both handshake inputs come from the CLKMPRE domain.
    always_ff @(posedge CLK_HS or posedge RESET) begin
        if (RESET) begin
            fsmind1_f1    <= 1'b0;
            fsmind1_f2    <= 1'b0;
            fsmind0ack_f1 <= 1'b0;
            fsmind0ack_f2 <= 1'b0;
        end else begin
            fsmind1_f1    <= FSMIND1;
            fsmind1_f2    <= fsmind1_f1;
            fsmind0ack_f1 <= FSMIND0ACK;
            fsmind0ack_f2 <= fsmind0ack_f1;
        end
    end

    always_ff @(posedge CLK_HS or posedge RESET) begin
        if (RESET) begin
            state      <= StIdle;
            cnt        <= '0;
            FSMIND1ACK <= 1'b0;
            FSMIND0    <= 1'b0;
            ROW_ADDR   <= '0;
            ROW_SEL    <= 1'b0;
            ADC_SAMPLE <= 1'b0;
            ROW_RST    <= 1'b0;
            ADC_ERR    <= 1'b0;
            FRAME_CNT  <= '0;
            fsm_stat   <= 8'h00;
        end else begin
            ADC_SAMPLE <= 1'b0;
            fsm_stat   <= state;
            case (state)
                StIdle: begin
                    if (fsmind1_f2) begin
                        FSMIND1ACK <= 1'b1;
                        ROW_ADDR   <= '0;
                        ROW_SEL    <= 1'b1;
                        cnt        <= '0;
                        state      <= StSettle;
                        fsm_stat   <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt == 16'(C_SETTLE - 1)) begin
                        ADC_SAMPLE <= 1'b1;
                        state      <= StSample;
                        fsm_stat   <= StSample;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StSample: begin
                    cnt      <= 16'd1;
                    state    <= StConv;
                    fsm_stat <= StConv;
                end
                StConv: begin
                    // A done in the final timeout cycle still counts as success.
                    if (ADC_DONE || cnt == 16'(C_ADC_TIMEOUT)) begin
                        if (!ADC_DONE) begin
                            ADC_ERR <= 1'b1;
                        end
                        ROW_RST  <= 1'b1;
                        cnt      <= '0;
                        state    <= StRowRst;
                        fsm_stat <= StRowRst;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StRowRst: begin
                    if (cnt == 16'(C_RST_CYC - 1)) begin
                        ROW_RST  <= 1'b0;
                        ROW_SEL  <= 1'b0;
                        state    <= StNext;
                        fsm_stat <= StNext;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                StNext: begin
                    if (ROW_ADDR == 8'(C_NUM_ROWS - 1)) begin
                        FSMIND0  <= 1'b1;
                        state    <= StDone;
                        fsm_stat <= StDone;
                    end else begin
                        ROW_ADDR <= ROW_ADDR + 8'd1;
                        ROW_SEL  <= 1'b1;
                        cnt      <= '0;
                        state    <= StSettle;
                        fsm_stat <= StSettle;
                    end
                end
                StDone: begin
                    // Needs a fresh ack and a released FSMIND1 to close the frame.
                    if (fsmind0ack_f2 && !fsmind1_f2) begin
                        FSMIND0    <= 1'b0;
                        FSMIND1ACK <= 1'b0;
                        FRAME_CNT  <= FRAME_CNT + 32'd1;
                        ROW_ADDR   <= '0;
                        state      <= StIdle;
                        fsm_stat   <= StIdle;
                    end
                end
                default: begin
                    state      <= StIdle;
                    cnt        <= '0;
                    FSMIND1ACK <= 1'b0;
                    FSMIND0    <= 1'b0;
                    ROW_ADDR   <= '0;
                    ROW_SEL    <= 1'b0;
                    ADC_SAMPLE <= 1'b0;
                    ROW_RST    <= 1'b0;
                    ADC_ERR    <= 1'b0;
                    FRAME_CNT  <= '0;
                    fsm_stat   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: doc/adc_readout_seq.md
Name: adc_readout_seq

Overview:
- Downstream partner of the exposure/mask-preload FSM. That FSM runs on CLKMPRE and raises FSMIND1 once the last subscene ends.
- This block runs on CLK_HS (the MOBO ADC side). It accepts the hand-off, sequences row-by-row readout of the pixel array through the TI-ADCs, then returns control with the FSMIND0 / FSMIND0ACK handshake.

Parameters:
- C_NUM_ROWS, 160, pixel rows read per frame (1..256).
- C_SETTLE, 8, CLK_HS cycles of row-select settling before the ADC sample.
- C_ADC_TIMEOUT, 64, maximum CLK_HS cycles to wait for ADC_DONE.
- C_RST_CYC, 4, CLK_HS cycles of per-row reset after conversion.

Ports:
- CLK_HS  input  1  readout clock; all logic is on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- FSMIND1  input  1  exposure FSM done, from the CLKMPRE domain (asynchronous).
- FSMIND1ACK  output  1  acknowledge for FSMIND1.
- FSMIND0  output  1  readout finished; exposure FSM may restart.
- FSMIND0ACK  input  1  acknowledge for FSMIND0, from the CLKMPRE domain (asynchronous).
- ROW_ADDR  output  8  current row address.
- ROW_SEL  output  1  row select enable.
- ADC_SAMPLE  output  1  one-cycle sample/convert-start strobe to the ADCs.
- ADC_DONE  input  1  conversion complete, synchronous to CLK_HS.
- ROW_RST  output  1  per-row pixel reset.
- ADC_ERR  output  1  sticky conversion-timeout flag.
- FRAME_CNT  output  32  completed readout frames.
- fsm_stat  output  8  state code for debug.

Behaviour:
- Reset (asynchronous, RESET=1):
  - All outputs 0, ROW_ADDR=0, FRAME_CNT=0, ADC_ERR=0, fsm_stat=8'h00, state=IDLE.
  - Synchronizer flops cleared.
  - Asserting RESET mid-frame aborts immediately; no partial handshake is kept.
- Synchronization: FSMIND1 and FSMIND0ACK each pass through a 2-flop synchronizer (f1, f2). The FSM uses only the f2 outputs.
- IDLE (fsm_stat 8'h01):
  - Outputs idle.
  - On f2(FSMIND1)=1: set FSMIND1ACK=1, ROW_ADDR=0, go to SETTLE.
  - FSMIND1ACK therefore rises on the 3rd CLK_HS edge after FSMIND1 is first sampled high.
- SETTLE (8'h02): ROW_SEL=1 for exactly C_SETTLE cycles, then SAMPLE.
- SAMPLE (8'h04): ADC_SAMPLE=1 for exactly one cycle, ROW_SEL=1; then CONV.
- CONV (8'h08):
  - ROW_SEL=1. Counts cycles from 1.
  - ADC_DONE=1 on cycle n≤C_ADC_TIMEOUT: go to ROWRST on the next edge.
  - Cycle C_ADC_TIMEOUT ends with no ADC_DONE: set ADC_ERR=1 (sticky until RESET), go to ROWRST anyway.
  - ADC_DONE seen in the timeout cycle itself counts as success.
  - ADC_DONE outside CONV is ignored.
- ROWRST (8'h10): ROW_SEL=1, ROW_RST=1 for exactly C_RST_CYC cycles, then NEXT.
- NEXT (8'h20): one cycle, ROW_SEL=0, ROW_RST=0.
  - If ROW_ADDR==C_NUM_ROWS-1: go to DONE, ROW_ADDR holds.
  - Otherwise ROW_ADDR+1 and go to SETTLE.
- Row period: C_SETTLE + 1 + n_conv + C_RST_CYC + 1 cycles.
- DONE (8'h40):
  - FSMIND0=1; FSMIND1ACK stays 1.
  - Leave when f2(FSMIND0ACK)=1 AND f2(FSMIND1)=0. On that edge: FSMIND0=0, FSMIND1ACK=0, FRAME_CNT+1 (wraps 2^32-1→0), ROW_ADDR=0, go to IDLE.
  - Both conditions are required so a stale FSMIND0ACK from the previous frame cannot end a frame, and a still-high FSMIND1 cannot retrigger.
- FSMIND1 falling during SETTLE..NEXT is ignored; the frame always completes.
- Illegal state: go to IDLE with all outputs at reset values.
- ROW_ADDR, ROW_SEL, ROW_RST and ADC_SAMPLE are registered and glitch-free.

Test Plan:
- C_NUM_ROWS=4, C_SETTLE=2, C_RST_CYC=1; raise FSMIND1; ADC_DONE returns 3 cycles after each ADC_SAMPLE -> FSMIND1ACK rises on edge 3; ROW_ADDR steps 0,1,2,3; exactly 4 ADC_SAMPLE pulses; each row period is 2+1+3+1+1=8 cycles; FSMIND0=1 after row 3; ADC_ERR=0.
- Handshake close: in DONE, hold FSMIND0ACK=1 while FSMIND1 stays 1 for 10 cycles, then drop FSMIND1 -> FSMIND0 stays 1 until f2(FSMIND1)=0; then FSMIND0 and FSMIND1ACK fall together, FRAME_CNT=1, state IDLE.
- Timeout: C_ADC_TIMEOUT=5, never assert ADC_DONE on row 2 -> CONV lasts exactly 5 cycles; ADC_ERR=1 from then on, persists into the next frame; all rows still read.
- Boundary: ADC_DONE exactly on cycle C_ADC_TIMEOUT -> no ADC_ERR. ADC_DONE pulsed during SETTLE -> ignored, still waits in CONV.
- Async RESET asserted mid-CONV of row 100 (default params) -> all outputs 0 immediately, without a clock edge. After release with FSMIND1=1 -> new frame starts from ROW_ADDR=0.
- FRAME_CNT preloaded via force to 32'hFFFFFFFF; complete one frame -> FRAME_CNT=0.
